dbus_slave: RTL and testbench

- Responder for the CPU core's data-memory port: it receives ram_addr/ram_data/ram_we/ram_sel/ram_ce and returns read data.
- It fronts a word-addressed data RAM and a small memory-mapped peripheral window (GPIO output register and a 32-bit compare timer with an interrupt flag).
- It sits beside the core in the SoC top, with its ports wired directly to the core's data-memory outputs and input.
- Reads are same-cycle, because the core's MEM stage consumes read data combinationally. Writes commit at the clock edge.

---
 rtl/dbus_pkg.sv | 28 ++
 rtl/dbus_timer.sv | 80 ++++++++
 rtl/dbus_slave.sv | 90 +++++++++
 tb/tb_dbus_slave.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared constants and byte-merge helper for the data-bus slave
package dbus_pkg;

    localparam logic [5:0] OFS_GPIO   = 6'd0;
    localparam logic [5:0] OFS_TCOUNT = 6'd1;
    localparam logic [5:0] OFS_TCMP   = 6'd2;
    localparam logic [5:0] OFS_TCTRL  = 6'd3;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_IRQ_FLAG    = 3;

    // Replace each byte of old_word whose lane enable is set with the matching byte of new_word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dbus_timer.sv
// rtl/dbus_timer.sv - 32-bit compare timer with auto-reload and sticky interrupt flag
module dbus_timer
    import dbus_pkg::*;
#(
    parameter logic [31:0] TIMER_RESET_CMP = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_count,
    input  logic        wr_cmp,
    input  logic        wr_ctrl,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    input  logic [1:0]  rd_ofs,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] count;
    logic [31:0] cmp;
    logic        en;
    logic        auto_reload;
    logic        irq_en;
    logic        irq_flag;
    logic        match;
    logic [31:0] ctrl_word;

    assign match     = en && (count == cmp);
    assign ctrl_word = {28'd0, irq_flag, irq_en, auto_reload, en};
    assign irq       = irq_flag & irq_en;

    // Counter, compare and control registers; every decision uses pre-edge values
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 32'd0;
            cmp         <= TIMER_RESET_CMP;
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            irq_flag    <= 1'b0;
        end else begin
            if (wr_count) begin
                count <= merge_bytes(count, wdata, sel);
            end else if (match && auto_reload) begin
                count <= 32'd0;
            end else if (en) begin
                count <= count + 32'd1;
            end

            if (wr_cmp) begin
                cmp <= merge_bytes(cmp, wdata, sel);
            end

            if (wr_ctrl && sel[0]) begin
                en          <= wdata[CTRL_EN];
                auto_reload <= wdata[CTRL_AUTO_RELOAD];
                irq_en      <= wdata[CTRL_IRQ_EN];
            end

            // A match in the same cycle as a write-1-to-clear keeps the flag set
            if (match) begin
                irq_flag <= 1'b1;
            end else if (wr_ctrl && sel[0] && wdata[CTRL_IRQ_FLAG]) begin
                irq_flag <= 1'b0;
            end
        end
    end

    // Read-back of the timer registers by low offset bits
    always_comb begin
        rdata = 32'd0;
        case (rd_ofs)
            OFS_TCOUNT[1:0]: rdata = count;
            OFS_TCMP[1:0]:   rdata = cmp;
            OFS_TCTRL[1:0]:  rdata = ctrl_word;
            default:         rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/dbus_slave.sv
// rtl/dbus_slave.sv - data-memory responder: word RAM plus GPIO/timer peripheral window
module dbus_slave
    import dbus_pkg::*;
#(
    parameter int          DEPTH_WORDS     = 1024,
    parameter logic [31:0] MMIO_BASE       = 32'hBFD0_0000,
    parameter logic [31:0] TIMER_RESET_CMP = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ram_ce_i,
    input  logic        ram_we_i,
    input  logic [31:0] ram_addr_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic [31:0] gpio_o,
    output logic        irq_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   gpio_out;
    logic [31:0]   timer_rdata;
    logic          active;
    logic          mmio_hit;
    logic [5:0]    ofs;
    logic [AW-1:0] idx;
    logic          mmio_wr;
    logic          unused_addr_bits;

    assign active   = |ram_ce_i;
    assign mmio_hit = (ram_addr_i[31:16] == MMIO_BASE[31:16]);
    assign ofs      = ram_addr_i[7:2];
    assign idx      = ram_addr_i[AW+1:2];
    assign mmio_wr  = active && ram_we_i && mmio_hit;
    assign gpio_o   = gpio_out;

    // Byte-lane and sub-window address bits that the decode deliberately ignores
    assign unused_addr_bits = ^{ram_addr_i[1:0], ram_addr_i[15:8]};

    // RAM has no reset, so writes commit even while rst is asserted
    always_ff @(posedge clk) begin
        if (active && ram_we_i && !mmio_hit) begin
            mem[idx] <= merge_bytes(mem[idx], ram_data_i, ram_sel_i);
        end
    end

    // GPIO output register
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out <= 32'd0;
        end else if (mmio_wr && (ofs == OFS_GPIO)) begin
            gpio_out <= merge_bytes(gpio_out, ram_data_i, ram_sel_i);
        end
    end

    dbus_timer #(
        .TIMER_RESET_CMP (TIMER_RESET_CMP)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .wr_count (mmio_wr && (ofs == OFS_TCOUNT)),
        .wr_cmp   (mmio_wr && (ofs == OFS_TCMP)),
        .wr_ctrl  (mmio_wr && (ofs == OFS_TCTRL)),
        .sel      (ram_sel_i),
        .wdata    (ram_data_i),
        .rd_ofs   (ofs[1:0]),
        .rdata    (timer_rdata),
        .irq      (irq_o)
    );

    // Same-cycle read mux; idle, write and unmapped accesses return zero
    always_comb begin
        ram_data_o = 32'd0;
        if (active && !ram_we_i) begin
            if (mmio_hit) begin
                if (ofs == OFS_GPIO) begin
                    ram_data_o = gpio_out;
                end else if (ofs < 6'd4) begin
                    ram_data_o = timer_rdata;
                end
            end else begin
                ram_data_o = mem[idx];
            end
        end
    end

endmodule

// File: tb/tb_dbus_slave.sv
// tb/tb_dbus_slave.sv - directed self-checking bench for dbus_slave
module tb_dbus_slave;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] A_GPIO  = 32'hBFD0_0000;
    localparam logic [31:0] A_COUNT = 32'hBFD0_0004;
    localparam logic [31:0] A_CMP   = 32'hBFD0_0008;
    localparam logic [31:0] A_CTRL  = 32'hBFD0_000C;
    localparam logic [31:0] A_UNMAP = 32'hBFD0_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ram_ce_i = 4'd0;
    logic        ram_we_i = 1'b0;
    logic [31:0] ram_addr_i = 32'd0;
    logic [3:0]  ram_sel_i = 4'd0;
    logic [31:0] ram_data_i = 32'd0;
    logic [31:0] ram_data_o;
    logic [31:0] gpio_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail = 0;

    dbus_slave #(
        .DEPTH_WORDS     (DEPTH),
        .MMIO_BASE       (32'hBFD0_0000),
        .TIMER_RESET_CMP (32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ram_ce_i   (ram_ce_i),
        .ram_we_i   (ram_we_i),
        .ram_addr_i (ram_addr_i),
        .ram_sel_i  (ram_sel_i),
        .ram_data_i (ram_data_i),
        .ram_data_o (ram_data_o),
        .gpio_o     (gpio_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ram_ce_i   = 4'd0;
        ram_we_i   = 1'b0;
        ram_sel_i  = 4'd0;
        ram_data_i = 32'd0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        ram_ce_i   = 4'b0001;
        ram_we_i   = 1'b1;
        ram_addr_i = addr;
        ram_data_i = data;
        ram_sel_i  = sel;
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] addr);
        ram_ce_i   = 4'b1000;
        ram_we_i   = 1'b0;
        ram_addr_i = addr;
        ram_sel_i  = 4'd0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (gpio_o !== 32'd0) begin n_fail++; $display("FAIL reset_gpio: got %h expected %h", gpio_o, 32'd0); end
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
        bus_read(A_CMP);
        n_checks++;
        if (ram_data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp: got %h expected ffffffff", ram_data_o); end
        bus_read(A_COUNT);
        n_checks++;
        if (ram_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", ram_data_o); end
        bus_read(A_CTRL);
        n_checks++;
        if (ram_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", ram_data_o); end
        bus_write(A_UNMAP, 32'h1234_5678, 4'hF);
        bus_read(A_UNMAP);
        n_checks++;
        if (ram_data_o !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", ram_data_o); end
        bus_idle();
    endtask

    task automatic test_byte_lanes();
        bus_write(32'h100, 32'h1122_3344, 4'hF);
        bus_write(32'h100, 32'hAABB_CCDD, 4'b0101);
        bus_read(32'h100);
        n_checks++;
        if (ram_data_o !== 32'h11BB_33DD) begin n_fail++; $display("FAIL byte_merge: got %h expected 11bb33dd", ram_data_o); end
        bus_read(32'h100 + 4 * DEPTH);
        n_checks++;
        if (ram_data_o !== 32'h11BB_33DD) begin n_fail++; $display("FAIL alias_read: got %h expected 11bb33dd", ram_data_o); end
        bus_write(32'h100, 32'h0000_0000, 4'h0);
        bus_read(32'h100);
        n_checks++;
        if (ram_data_o !== 32'h11BB_33DD) begin n_fail++; $display("FAIL sel_zero: got %h expected 11bb33dd", ram_data_o); end
        bus_write(A_GPIO, 32'h0000_00C3, 4'b0001);
        n_checks++;
        if (gpio_o !== 32'h0000_00C3) begin n_fail++; $display("FAIL gpio_lane: got %h expected 000000c3", gpio_o); end
        bus_idle();
    endtask

    task automatic test_read_during_write();
        bus_write(32'h200, 32'd0, 4'hF);
        ram_ce_i   = 4'b0010;
        ram_we_i   = 1'b1;
        ram_addr_i = 32'h200;
        ram_data_i = 32'hDEAD_BEEF;
        ram_sel_i  = 4'hF;
        #1;
        n_checks++;
        if (ram_data_o !== 32'd0) begin n_fail++; $display("FAIL rdw_write_cycle: got %h expected 0", ram_data_o); end
        tick();
        bus_read(32'h200);
        n_checks++;
        if (ram_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdw_next_read: got %h expected deadbeef", ram_data_o); end
        ram_ce_i = 4'd0;
        #1;
        n_checks++;
        if (ram_data_o !== 32'd0) begin n_fail++; $display("FAIL ce_zero: got %h expected 0", ram_data_o); end
        bus_idle();
    endtask

    task automatic wait_count(input logic [31:0] target);
        int budget;
        budget = 0;
        bus_read(A_COUNT);
        while (ram_data_o !== target && budget < 40) begin
            tick();
            bus_read(A_COUNT);
            budget++;
        end
        n_checks++;
        if (ram_data_o !== target) begin n_fail++; $display("FAIL wait_count: got %h expected %h", ram_data_o, target); end
    endtask

    task automatic test_timer_reload();
        logic [31:0] exp_seq [8];
        exp_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
        bus_write(A_CMP, 32'd5, 4'hF);
        bus_write(A_COUNT, 32'd0, 4'hF);
        bus_write(A_CTRL, 32'h7, 4'hF);
        for (int k = 0; k < 8; k++) begin
            bus_read(A_COUNT);
            n_checks++;
            if (ram_data_o !== exp_seq[k]) begin n_fail++; $display("FAIL reload_count[%0d]: got %h expected %h", k, ram_data_o, exp_seq[k]); end
            n_checks++;
            if (irq_o !== (k >= 6)) begin n_fail++; $display("FAIL reload_irq[%0d]: got %b expected %b", k, irq_o, (k >= 6)); end
            tick();
        end
        bus_write(A_CTRL, 32'hF, 4'hF);
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL w1c_clear: got %b expected 0", irq_o); end
        bus_idle();
    endtask

    task automatic test_set_beats_clear();
        wait_count(32'd5);
        bus_write(A_CTRL, 32'hF, 4'hF);
        n_checks++;
        if (irq_o !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq: got %b expected 1", irq_o); end
        bus_read(A_COUNT);
        n_checks++;
        if (ram_data_o !== 32'd0) begin n_fail++; $display("FAIL set_wins_count: got %h expected 0", ram_data_o); end
        bus_write(A_CTRL, 32'hF, 4'hF);
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL clear_again: got %b expected 0", irq_o); end
        wait_count(32'd5);
        bus_write(A_COUNT, 32'd100, 4'hF);
        bus_read(A_COUNT);
        n_checks++;
        if (ram_data_o !== 32'd100) begin n_fail++; $display("FAIL count_write_prio: got %h expected 00000064", ram_data_o); end
        bus_read(A_CTRL);
        n_checks++;
        if (ram_data_o !== 32'hF) begin n_fail++; $display("FAIL match_flag_on_write: got %h expected 0000000f", ram_data_o); end
        bus_idle();
    endtask

    task automatic test_wrap();
        bus_write(A_CTRL, 32'h8, 4'hF);
        bus_write(A_CMP, 32'd3, 4'hF);
        bus_write(A_COUNT, 32'hFFFF_FFFF, 4'hF);
        bus_write(A_CTRL, 32'h1, 4'hF);
        bus_read(A_COUNT);
        n_checks++;
        if (ram_data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_start: got %h expected ffffffff", ram_data_o); end
        tick();
        bus_read(A_COUNT);
        n_checks++;
        if (ram_data_o !== 32'd0) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0", ram_data_o); end
        for (int k = 0; k < 3; k++) begin
            bus_read(A_CTRL);
            n_checks++;
            if (ram_data_o !== 32'h1) begin n_fail++; $display("FAIL wrap_noflag[%0d]: got %h expected 00000001", k, ram_data_o); end
            tick();
        end
        tick();
        bus_read(A_CTRL);
        n_checks++;
        if (ram_data_o !== 32'h9) begin n_fail++; $display("FAIL wrap_flag: got %h expected 00000009", ram_data_o); end
        bus_idle();
    endtask

    task automatic test_mid_reset();
        bus_write(A_GPIO, 32'hA5A5_A5A5, 4'hF);
        bus_write(A_CTRL, 32'h5, 4'hF);
        n_checks++;
        if (irq_o !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq_o); end
        n_checks++;
        if (gpio_o !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL pre_reset_gpio: got %h expected a5a5a5a5", gpio_o); end
        rst = 1'b1;
        bus_write(A_GPIO, 32'h1234_5678, 4'hF);
        rst = 1'b0;
        n_checks++;
        if (gpio_o !== 32'd0) begin n_fail++; $display("FAIL mid_reset_gpio: got %h expected 0", gpio_o); end
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: got %b expected 0", irq_o); end
        bus_read(A_COUNT);
        n_checks++;
        if (ram_data_o !== 32'd0) begin n_fail++; $display("FAIL mid_reset_count: got %h expected 0", ram_data_o); end
        bus_read(A_CMP);
        n_checks++;
        if (ram_data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mid_reset_cmp: got %h expected ffffffff", ram_data_o); end
        bus_read(32'h100);
        n_checks++;
        if (ram_data_o !== 32'h11BB_33DD) begin n_fail++; $display("FAIL ram_keep_100: got %h expected 11bb33dd", ram_data_o); end
        bus_read(32'h200);
        n_checks++;
        if (ram_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_keep_200: got %h expected deadbeef", ram_data_o); end
        bus_idle();
    endtask

    initial begin
        bus_idle();
        #1;
        test_reset();
        test_byte_lanes();
        test_read_during_write();
        test_timer_reload();
        test_set_beats_clear();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
